// File: rtl/rs_pkg.sv
// Shared types and helpers for the parametrised reservation station.
package rs_pkg;

  typedef enum logic [1:0] {
    RS_FREE  = 2'd0,
    RS_WAIT  = 2'd1,
    RS_READY = 2'd2,
    RS_EXEC  = 2'd3
  } rs_state_e;

  localparam int TAG_NONE = 0;

  function automatic logic tag_owned(input int unsigned tag,
                                     input int unsigned base,
                                     input int unsigned depth);
    return (tag >= base) && (tag < base + depth);
  endfunction

endpackage

// File: rtl/res_station_n_if.sv
// Allocation, CDB and issue signals of one reservation station.
interface res_station_n_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int OP_W   = 2
) ();
  logic              alloc_en;
  logic [OP_W-1:0]   alloc_op;
  logic [DATA_W-1:0] alloc_vj;
  logic [DATA_W-1:0] alloc_vk;
  logic [TAG_W-1:0]  alloc_qj;
  logic [TAG_W-1:0]  alloc_qk;
  logic [TAG_W-1:0]  alloc_tag;
  logic              full;
  logic              cdb_en;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              issue_ready;
  logic              issue_valid;
  logic [OP_W-1:0]   issue_op;
  logic [DATA_W-1:0] issue_a;
  logic [DATA_W-1:0] issue_b;
  logic [TAG_W-1:0]  issue_tag;

  modport master (
    output alloc_en, alloc_op, alloc_vj, alloc_vk, alloc_qj, alloc_qk,
    output cdb_en, cdb_tag, cdb_data, issue_ready,
    input  alloc_tag, full, issue_valid, issue_op, issue_a, issue_b, issue_tag
  );

  modport slave (
    input  alloc_en, alloc_op, alloc_vj, alloc_vk, alloc_qj, alloc_qk,
    input  cdb_en, cdb_tag, cdb_data, issue_ready,
    output alloc_tag, full, issue_valid, issue_op, issue_a, issue_b, issue_tag
  );
endinterface

// File: rtl/rs_pick_oldest.sv
// Grants the ready entry with the largest age; lowest index wins any tie.
module rs_pick_oldest #(
  parameter int DEPTH = 4,
  parameter int AGE_W = 2
) (
  input  logic [DEPTH-1:0] ready,
  input  logic [AGE_W-1:0] age [DEPTH],
  output logic [DEPTH-1:0] grant,
  output logic             valid
);
  logic [AGE_W-1:0] best;

  always_comb begin
    grant = '0;
    valid = 1'b0;
    best  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && (!valid || age[i] > best)) begin
        grant    = '0;
        grant[i] = 1'b1;
        valid    = 1'b1;
        best     = age[i];
      end
    end
  end
endmodule

// File: rtl/res_station_n.sv
// Reservation station: CDB-snooping operand rename, oldest-first issue,
// entries held in EXEC until their own tag is broadcast.
module res_station_n
  import rs_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int DATA_W   = 32,
  parameter int TAG_W    = 4,
  parameter int OP_W     = 2,
  parameter int TAG_BASE = 1
) (
  input  logic           clk,
  input  logic           RST,
  res_station_n_if.slave bus
);
  localparam int AGE_W = $clog2(DEPTH);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(DEPTH - 1);

  rs_state_e         st   [DEPTH];
  logic [AGE_W-1:0]  age  [DEPTH];
  logic [OP_W-1:0]   op   [DEPTH];
  logic [DATA_W-1:0] vj   [DEPTH];
  logic [DATA_W-1:0] vk   [DEPTH];
  logic [DEPTH-1:0]  rdy_mask;
  logic [DEPTH-1:0]  grant;
  logic              pick_vld;
  logic [IDX_W-1:0]  free_idx;
  logic              any_free;
  logic              alloc_fire;
  logic              issue_fire;
  logic              cdb_live;
  logic              cdb_own;
  logic              byp_j;
  logic              byp_k;

  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (st[i] == RS_FREE) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign bus.full      = !any_free;
  assign bus.alloc_tag = any_free ? TAG_W'(TAG_BASE + int'(free_idx)) : TAG_W'(TAG_BASE);

  assign alloc_fire = bus.alloc_en && any_free;
  assign issue_fire = pick_vld && bus.issue_ready;
  assign cdb_live   = bus.cdb_en && (bus.cdb_tag != TAG_W'(TAG_NONE));
  assign cdb_own    = bus.cdb_en && tag_owned(32'(bus.cdb_tag), TAG_BASE, DEPTH);
  assign byp_j      = cdb_live && (bus.alloc_qj == bus.cdb_tag);
  assign byp_k      = cdb_live && (bus.alloc_qk == bus.cdb_tag);

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    localparam logic [TAG_W-1:0] OWN_TAG = TAG_W'(TAG_BASE + i);

    rs_state_e         st_r;
    logic [AGE_W-1:0]  age_r;
    logic [TAG_W-1:0]  qj_r, qk_r, qj_n, qk_n;
    logic [DATA_W-1:0] vj_r, vk_r, vj_n, vk_n;
    logic [OP_W-1:0]   op_r;
    logic              hit;
    logic              rel;

    assign hit = alloc_fire && (free_idx == IDX_W'(i));
    assign rel = cdb_own && (bus.cdb_tag == OWN_TAG);

    // Operand next-state: fresh allocation with bypass, or snoop while waiting
    always_comb begin
      qj_n = qj_r;
      qk_n = qk_r;
      vj_n = vj_r;
      vk_n = vk_r;
      if (hit) begin
        qj_n = byp_j ? '0 : bus.alloc_qj;
        qk_n = byp_k ? '0 : bus.alloc_qk;
        vj_n = byp_j ? bus.cdb_data : bus.alloc_vj;
        vk_n = byp_k ? bus.cdb_data : bus.alloc_vk;
      end else if (st_r == RS_WAIT && cdb_live) begin
        if (qj_r == bus.cdb_tag) begin
          qj_n = '0;
          vj_n = bus.cdb_data;
        end
        if (qk_r == bus.cdb_tag) begin
          qk_n = '0;
          vk_n = bus.cdb_data;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (RST) begin
        st_r  <= RS_FREE;
        age_r <= '0;
        qj_r  <= '0;
        qk_r  <= '0;
      end else begin
        qj_r <= qj_n;
        qk_r <= qk_n;
        if (hit) begin
          st_r  <= (qj_n == '0 && qk_n == '0) ? RS_READY : RS_WAIT;
          age_r <= '0;
        end else begin
          if (alloc_fire && st_r != RS_FREE && age_r != AGE_MAX)
            age_r <= age_r + 1'b1;
          unique case (st_r)
            RS_WAIT:  if (qj_n == '0 && qk_n == '0) st_r <= RS_READY;
            RS_READY: if (issue_fire && grant[i])   st_r <= RS_EXEC;
            RS_EXEC:  if (rel)                      st_r <= RS_FREE;
            default: ;
          endcase
        end
      end
    end

    always_ff @(posedge clk) begin
      if (hit) op_r <= bus.alloc_op;
      vj_r <= vj_n;
      vk_r <= vk_n;
    end

    assign st[i]       = st_r;
    assign age[i]      = age_r;
    assign op[i]       = op_r;
    assign vj[i]       = vj_r;
    assign vk[i]       = vk_r;
    assign rdy_mask[i] = (st_r == RS_READY);
  end

  rs_pick_oldest #(
    .DEPTH (DEPTH),
    .AGE_W (AGE_W)
  ) u_pick (
    .ready (rdy_mask),
    .age   (age),
    .grant (grant),
    .valid (pick_vld)
  );

  always_comb begin
    bus.issue_valid = pick_vld;
    bus.issue_op    = '0;
    bus.issue_a     = '0;
    bus.issue_b     = '0;
    bus.issue_tag   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        bus.issue_op  = op[i];
        bus.issue_a   = vj[i];
        bus.issue_b   = vk[i];
        bus.issue_tag = TAG_W'(TAG_BASE + i);
      end
    end
  end
endmodule
